alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 115 +++++++++++
 tb/tb_alu_op_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Serialises a word-wide logic command onto a 1-bit ALU,
//               LSB first, and reassembles the returned bits into a word.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    output logic             op_a,
    output logic             op_b,
    output logic             bit_i0,
    output logic             bit_i1,
    output logic             bit_valid,
    input  logic             alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_res;
    logic [1:0]         r_op;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_legal;
    logic               w_last;
    logic [1:0]         w_enc;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_legal  = (cmd_op != 4'd0) && ((cmd_op & (cmd_op - 4'd1)) == 4'd0);
    assign w_last   = (r_cnt == c_LAST);

    always_comb begin
        w_enc = 2'b00;
        if (cmd_op[1]) w_enc = 2'b01;
        if (cmd_op[2]) w_enc = 2'b10;
        if (cmd_op[3]) w_enc = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = w_legal ? S_ISSUE : S_DONE;
            S_ISSUE: if (w_last)    w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operands shift right so bit k always sits at [0]; results shift in from
    // the top so bit 0 lands in res_data[0] after WIDTH captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_res <= '0;
            r_op  <= 2'b00;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_x   <= cmd_x;
            r_y   <= cmd_y;
            r_op  <= w_enc;
            r_err <= ~w_legal;
            r_res <= '0;
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_x   <= r_x >> 1;
            r_y   <= r_y >> 1;
            r_res <= {alu_out, r_res[WIDTH-1:1]};
            if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign bit_valid = (r_state == S_ISSUE);
    assign op_a      = bit_valid & r_op[1];
    assign op_b      = bit_valid & r_op[0];
    assign bit_i0    = bit_valid & r_x[0];
    assign bit_i1    = bit_valid & r_y[0];
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res;
    assign res_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Scoreboard bench for alu_op_sequencer with a 1-bit ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = 4'd0;
    logic [WIDTH-1:0] cmd_x = '0;
    logic [WIDTH-1:0] cmd_y = '0;
    logic             op_a, op_b, bit_i0, bit_i1, bit_valid;
    logic             alu_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic             res_err;

    int               total = 0;
    int               bad = 0;
    logic [WIDTH:0]   sb_q[$];

    alu_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .op_a(op_a), .op_b(op_b), .bit_i0(bit_i0), .bit_i1(bit_i1),
        .bit_valid(bit_valid), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = 1'b0;
        if (bit_valid) begin
            case ({op_a, op_b})
                2'b00:   alu_out = bit_i0 & bit_i1;
                2'b01:   alu_out = bit_i0 | bit_i1;
                2'b10:   alu_out = bit_i0 ^ bit_i1;
                default: alu_out = ~bit_i0;
            endcase
        end
    end

    // Whenever nothing is issued, the ALU-side lines must be quiet.
    always @(negedge clk) begin
        if (bit_valid === 1'b0) begin
            total++;
            if ({op_a, op_b, bit_i0, bit_i1} !== 4'b0000) begin
                bad++;
                $display("FAIL idle_lines: got %b want 0000", {op_a, op_b, bit_i0, bit_i1});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n = 0;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++; bad++;
            $display("FAIL send_timeout: cmd_ready never 1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom);
        cmd_x = WIDTH'($urandom);
        cmd_y = WIDTH'($urandom);
    endtask

    task automatic wait_result(output int lat, output int nbits, output logic [1:0] opc,
                               output bit opc_moved, output bit timed_out);
        lat = 0; nbits = 0; opc = 2'b00; opc_moved = 1'b0; timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lat++;
            if (bit_valid === 1'b1) begin
                if (nbits == 0) opc = {op_a, op_b};
                else if ({op_a, op_b} !== opc) opc_moved = 1'b1;
                nbits++;
            end
            if (res_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [1:0] exp_opc,
                          input logic exp_err, input logic [WIDTH-1:0] exp_data);
        int lat, nbits, exp_lat, exp_bits;
        logic [1:0] opc;
        bit moved, tmo;
        logic [WIDTH:0] exp;
        exp_bits = exp_err ? 0 : WIDTH;
        exp_lat  = exp_err ? 1 : WIDTH + 1;
        sb_q.push_back({exp_err, exp_data});
        send(op, x, y);
        wait_result(lat, nbits, opc, moved, tmo);
        total++;
        if (tmo) begin
            bad++;
            $display("FAIL %s_timeout: res_valid never rose", name);
            void'(sb_q.pop_front());
            return;
        end
        exp = sb_q.pop_front();
        if (res_data !== exp[WIDTH-1:0]) begin
            bad++; $display("FAIL %s_data: got %h want %h", name, res_data, exp[WIDTH-1:0]);
        end
        total++;
        if (res_err !== exp[WIDTH]) begin
            bad++; $display("FAIL %s_err: got %b want %b", name, res_err, exp[WIDTH]);
        end
        total++;
        if (lat !== exp_lat) begin
            bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        total++;
        if (nbits !== exp_bits) begin
            bad++; $display("FAIL %s_bitcount: got %0d want %0d", name, nbits, exp_bits);
        end
        if (!exp_err) begin
            total++;
            if (opc !== exp_opc || moved) begin
                bad++; $display("FAIL %s_opcode: got %b moved=%0d want %b", name, opc, moved, exp_opc);
            end
        end
        handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'b0001; cmd_x = 8'hFF; cmd_y = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cmd_ready, bit_valid, res_valid, res_err} !== 4'b1000 || res_data !== '0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b bv=%b rv=%b err=%b data=%h want 1 0 0 0 00",
                     cmd_ready, bit_valid, res_valid, res_err, res_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || bit_valid !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ignores_cmd: got rdy=%b bv=%b rv=%b want 1 0 0", cmd_ready, bit_valid, res_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_and();
        run_op("and", 4'b0001, 8'hF0, 8'hCC, 2'b00, 1'b0, 8'hC0);
    endtask

    task automatic test_xor_not();
        run_op("xor", 4'b0100, 8'hA5, 8'h0F, 2'b10, 1'b0, 8'hAA);
        run_op("not", 4'b1000, 8'hA5, 8'h33, 2'b11, 1'b0, 8'h5A);
    endtask

    task automatic test_illegal();
        run_op("illegal_two", 4'b0011, 8'hFF, 8'hFF, 2'b00, 1'b1, 8'h00);
        run_op("illegal_zero", 4'b0000, 8'h5A, 8'hA5, 2'b00, 1'b1, 8'h00);
    endtask

    task automatic test_stall();
        int lat, nbits;
        logic [1:0] opc;
        bit moved, tmo;
        logic [WIDTH:0] exp;
        sb_q.push_back({1'b0, 8'h99});
        send(4'b0010, 8'h81, 8'h18);
        wait_result(lat, nbits, opc, moved, tmo);
        exp = sb_q.pop_front();
        total++;
        if (tmo || res_data !== exp[WIDTH-1:0] || opc !== 2'b01) begin
            bad++; $display("FAIL stall_first: got data=%h opc=%b tmo=%0d want %h 01", res_data, opc, tmo, exp[WIDTH-1:0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (res_valid !== 1'b1 || res_data !== exp[WIDTH-1:0] || res_err !== 1'b0 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: got rv=%b data=%h err=%b rdy=%b want 1 %h 0 0",
                         i, res_valid, res_data, res_err, cmd_ready, exp[WIDTH-1:0]);
            end
        end
        handshake();
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: got rdy=%b rv=%b want 1 0", cmd_ready, res_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        send(4'b0010, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bit_valid !== 1'b1) begin
            bad++; $display("FAIL abort_in_issue: got bv=%b want 1", bit_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bit_valid !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_data !== '0) begin
            bad++;
            $display("FAIL abort_state: got bv=%b rv=%b rdy=%b data=%h want 0 0 1 00",
                     bit_valid, res_valid, cmd_ready, res_data);
        end
        @(posedge clk);
        #1;
        run_op("after_abort", 4'b0001, 8'hFF, 8'h3C, 2'b00, 1'b0, 8'h3C);
    endtask

    task automatic test_back_to_back();
        int acc[2], hs[2];
        int nacc = 0, nh = 0;
        logic [WIDTH:0] exp;
        res_ready = 1'b1;
        cmd_op = 4'b0001; cmd_x = 8'h5A; cmd_y = 8'h3C; cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready === 1'b1 && nacc < 2) begin
                acc[nacc] = cyc; nacc++;
                sb_q.push_back({1'b0, 8'h18});
            end
            if (res_valid === 1'b1 && nh < 2) begin
                hs[nh] = cyc; nh++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
                total++;
                if (res_data !== exp[WIDTH-1:0] || res_err !== exp[WIDTH]) begin
                    bad++; $display("FAIL b2b_data%0d: got %b_%h want %b_%h", nh, res_err, res_data, exp[WIDTH], exp[WIDTH-1:0]);
                end
                if (nh == 2) begin
                    cmd_valid = 1'b0;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        total++;
        if (nacc != 2 || nh != 2) begin
            bad++; $display("FAIL b2b_count: got acc=%0d hs=%0d want 2 2", nacc, nh);
        end else begin
            total++;
            if (acc[1] != hs[0] + 1) begin
                bad++; $display("FAIL b2b_gap: got accept at %0d after handshake %0d want %0d", acc[1], hs[0], hs[0] + 1);
            end
            total++;
            if (hs[0] != acc[0] + WIDTH + 1) begin
                bad++; $display("FAIL b2b_latency: got %0d want %0d", hs[0] - acc[0], WIDTH + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_xor_not();
        test_illegal();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
